// File: rtl/disp_scan_8dig_pkg.sv
// Shared types and sizes for the 8-digit display scanner.
// Holds the scan FSM state encoding and digit-count constants.
package disp_scan_8dig_pkg;

    typedef enum logic {
        S_ON    = 1'b0,
        S_GUARD = 1'b1
    } state_t;

    localparam int NDIG  = 8;
    localparam int SEL_W = 3;

endpackage

// File: rtl/disp_scan_8dig_tick.sv
// scan_tick_gen: prescaler for the display scanner.
// Ports: clk, reset (sync, active-high), state (current scan
// phase); tick pulses on the last cycle of the DIV or GUARD
// interval, whichever the current state selects.
module scan_tick_gen
    import disp_scan_8dig_pkg::*;
#(
    parameter int DIV   = 125000,
    parameter int GUARD = 4,
    parameter int CNT_W = 17
) (
    input  logic   clk,
    input  logic   reset,
    input  state_t state,
    output logic   tick
);

    localparam logic [CNT_W-1:0] DIV_LIM   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == ((state == S_ON) ? DIV_LIM : GUARD_LIM));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/disp_scan_8dig.sv
// disp_scan_8dig: time-multiplexed scan controller for 8 seven-
// segment digits with guard blanking and frame-synchronous commit.
// Ports: clk, reset (sync, active-high); load/data_in/blank_in/
// dp_in stage new contents; sel/en_digit feed the board-level
// 3-to-8 decoder; hex/dp carry the selected digit; frame_done and
// load_ack are one-cycle pulses on the first cycle of a new frame.
module disp_scan_8dig
    import disp_scan_8dig_pkg::*;
#(
    parameter int DIV   = 125000,
    parameter int GUARD = 4,
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [31:0]      data_in,
    input  logic [NDIG-1:0]  blank_in,
    input  logic [NDIG-1:0]  dp_in,
    output logic [SEL_W-1:0] sel,
    output logic             en_digit,
    output logic [3:0]       hex,
    output logic             dp,
    output logic             frame_done,
    output logic             load_ack
);

    state_t state;
    state_t state_next;
    logic   tick;
    logic   wrap;

    logic [31:0]     data_reg;
    logic [NDIG-1:0] blank_reg;
    logic [NDIG-1:0] dp_reg;
    logic [31:0]     data_pend;
    logic [NDIG-1:0] blank_pend;
    logic [NDIG-1:0] dp_pend;
    logic            pend;

    scan_tick_gen #(
        .DIV   (DIV),
        .GUARD (GUARD),
        .CNT_W (CNT_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .state (state),
        .tick  (tick)
    );

    // Last cycle of digit 7's guard: sel wraps to 0 on this edge.
    assign wrap = tick && (state == S_GUARD) && (sel == SEL_W'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_ON;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_ON:    if (tick) state_next = S_GUARD;
            S_GUARD: if (tick) state_next = S_ON;
            default: state_next = S_ON;
        endcase
    end

    always_comb begin
        en_digit = 1'b0;
        hex      = data_reg[{sel, 2'b00} +: 4];
        if (state == S_ON) begin
            en_digit = ~blank_reg[sel];
        end
        dp = dp_reg[sel] & en_digit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel <= '0;
        end else if (tick && (state == S_GUARD)) begin
            sel <= sel + SEL_W'(1);
        end
    end

    // A load in the wrap cycle itself is newer than anything pending,
    // so it goes straight to the shadow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg   <= '0;
            blank_reg  <= '1;
            dp_reg     <= '0;
            data_pend  <= '0;
            blank_pend <= '0;
            dp_pend    <= '0;
            pend       <= 1'b0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            frame_done <= wrap;
            load_ack   <= wrap && (pend || load);
            if (wrap) begin
                pend <= 1'b0;
                if (load) begin
                    data_reg  <= data_in;
                    blank_reg <= blank_in;
                    dp_reg    <= dp_in;
                end else if (pend) begin
                    data_reg  <= data_pend;
                    blank_reg <= blank_pend;
                    dp_reg    <= dp_pend;
                end
            end else if (load) begin
                data_pend  <= data_in;
                blank_pend <= blank_in;
                dp_pend    <= dp_in;
                pend       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_8dig.sv
// Randomized self-checking bench for disp_scan_8dig with a
// cycle-position reference model (DIV=4, GUARD=2).
module tb_disp_scan_8dig;

    localparam int DIV   = 4;
    localparam int GUARD = 2;
    localparam int PER   = DIV + GUARD;
    localparam int FRAME = 8 * PER;

    logic        clk;
    logic        reset;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  blank_in;
    logic [7:0]  dp_in;
    logic [2:0]  sel;
    logic        en_digit;
    logic [3:0]  hex;
    logic        dp;
    logic        frame_done;
    logic        load_ack;

    disp_scan_8dig #(
        .DIV   (DIV),
        .GUARD (GUARD),
        .CNT_W (17)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .blank_in   (blank_in),
        .dp_in      (dp_in),
        .sel        (sel),
        .en_digit   (en_digit),
        .hex        (hex),
        .dp         (dp),
        .frame_done (frame_done),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acks  = 0;

    // Model: position within the frame plus shadow/pending contents.
    int          t;
    logic [31:0] m_data;
    logic [7:0]  m_blank;
    logic [7:0]  m_dp;
    logic [31:0] p_data;
    logic [7:0]  p_blank;
    logic [7:0]  p_dp;
    logic        m_pend;
    logic        m_fd;
    logic        m_ack;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic check_all();
        int          s;
        logic        on;
        logic        en;
        logic [31:0] d;
        s  = (t / PER) % 8;
        on = (t % PER) < DIV;
        en = on && !m_blank[s];
        d  = m_data >> (4 * s);
        chk("sel", 32'(sel), 32'(s));
        chk("en_digit", 32'(en_digit), 32'(en));
        chk("hex", 32'(hex), d & 32'hF);
        chk("dp", 32'(dp), 32'(m_dp[s] & en));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("load_ack", 32'(load_ack), 32'(m_ack));
    endtask

    task automatic step(input logic rs, input logic ld,
                        input logic [31:0] d, input logic [7:0] b,
                        input logic [7:0] p);
        logic bnd;
        reset    = rs;
        load     = ld;
        data_in  = d;
        blank_in = b;
        dp_in    = p;
        @(posedge clk);
        if (rs) begin
            t       = 0;
            m_data  = '0;
            m_blank = 8'hFF;
            m_dp    = '0;
            p_data  = '0;
            p_blank = '0;
            p_dp    = '0;
            m_pend  = 1'b0;
            m_fd    = 1'b0;
            m_ack   = 1'b0;
        end else begin
            bnd   = (t == FRAME - 1);
            m_fd  = bnd;
            m_ack = bnd && (m_pend || ld);
            if (bnd) begin
                if (ld) begin
                    m_data  = d;
                    m_blank = b;
                    m_dp    = p;
                end else if (m_pend) begin
                    m_data  = p_data;
                    m_blank = p_blank;
                    m_dp    = p_dp;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                p_data  = d;
                p_blank = b;
                p_dp    = p;
                m_pend  = 1'b1;
            end
            t = (t + 1) % FRAME;
        end
        @(negedge clk);
        if (load_ack === 1'b1) n_acks++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic idle_to(input int pos);
        for (int i = 0; i < FRAME && t != pos; i++) begin
            step(1'b0, 1'b0, '0, '0, '0);
        end
        chk("reach_pos", 32'(t), 32'(pos));
    endtask

    initial begin
        int a0;
        clk      = 1'b0;
        reset    = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        blank_in = '0;
        dp_in    = '0;
        t        = 0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, '0);
        idle(FRAME + 2);

        idle_to(20);
        step(1'b0, 1'b1, 32'h76543210, 8'h00, 8'h81);
        idle(2 * FRAME);

        idle_to(5);
        a0 = n_acks;
        step(1'b0, 1'b1, 32'h11111111, 8'h00, 8'h00);
        idle(10);
        step(1'b0, 1'b1, 32'h22222222, 8'h00, 8'h00);
        idle(FRAME);
        chk("single_ack", 32'(n_acks - a0), 32'd1);

        idle_to(FRAME - 1);
        step(1'b0, 1'b1, 32'hABCDEF01, 8'h00, 8'h10);
        chk("bypass_hex", 32'(hex), 32'h1);
        chk("bypass_ack", 32'(load_ack), 32'h1);
        idle(FRAME);

        idle_to(3);
        step(1'b0, 1'b1, 32'h89ABCDEF, 8'b0000_0100, 8'hFF);
        idle(2 * FRAME);

        idle_to(10);
        step(1'b0, 1'b1, 32'hFEDCBA98, 8'h00, 8'h00);
        idle_to(5 * PER + DIV);
        a0 = n_acks;
        step(1'b1, 1'b0, '0, '0, '0);
        chk("rst_sel", 32'(sel), 32'd0);
        idle(2 * FRAME);
        chk("no_ack_after_rst", 32'(n_acks - a0), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 11) == 0),
                 $urandom(), 8'($urandom()), 8'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
